// File: rtl/fetch_thr_sched.sv
// Four-thread IFU fetch scheduler. It picks one runnable thread per cycle,
// round-robin with an urgent override, registers the F-stage thread/PC/valid
// and owns the four per-thread fetch PC registers.
//
// Handshake: a fetch is accepted on any edge where thr_s is non-zero. thr_s is
// already forced to zero while fetch_stall is high, so fetch_stall acts as the
// "not ready" side of a valid/ready pair. There is no backpressure beyond that.
module fetch_thr_sched #(
    parameter logic [47:0] RESET_PC = 48'h0000_0000_0020,
    parameter logic [47:0] PC_INC   = 48'd4
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic [3:0]  thr_rdy,
    input  logic [3:0]  thr_urgent,
    input  logic        fetch_stall,
    input  logic        redirect_vld,
    input  logic [1:0]  redirect_thr,
    input  logic [47:0] redirect_pc,
    output logic [3:0]  thr_s,
    output logic        running_s,
    output logic [3:0]  thr_f,
    output logic [47:0] pc_f,
    output logic        inst_vld_f,
    output logic [47:0] t0pc_f,
    output logic [47:0] t1pc_f,
    output logic [47:0] t2pc_f,
    output logic [47:0] t3pc_f
);

    logic [47:0] r_pc [4];
    logic [3:0]  r_thr_f;
    logic [47:0] r_pc_f;
    logic        r_inst_vld;
    logic [1:0]  r_last;

    logic [3:0]  w_redir_mask;
    logic [3:0]  w_elig;
    logic [3:0]  w_urg;
    logic [3:0]  w_search;
    logic        w_pick_vld;
    logic [1:0]  w_pick_idx;
    logic [3:0]  w_thr_s;
    logic        w_accept;
    logic        w_kill;

    // A thread being redirected this cycle is excluded from selection so its
    // PC never sees an increment and a redirect at the same edge.
    assign w_redir_mask = redirect_vld ? (4'b0001 << redirect_thr) : 4'b0000;
    assign w_elig       = thr_rdy & ~w_redir_mask;
    assign w_urg        = w_elig & thr_urgent;
    assign w_search     = (w_urg != 4'b0000) ? w_urg : w_elig;

    // Round-robin search starting at last+1; first set bit wins.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            if (!w_pick_vld && w_search[r_last + 2'(k)]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = r_last + 2'(k);
            end
        end
    end

    assign w_thr_s  = (fetch_stall || !w_pick_vld) ? 4'b0000 : (4'b0001 << w_pick_idx);
    assign w_accept = |w_thr_s;
    // Redirect of the thread currently held in F squashes that fetch.
    assign w_kill   = redirect_vld && r_inst_vld && r_thr_f[redirect_thr];

    // Per-thread PC registers: redirect overwrites, accepted fetch increments.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < 4; i++) begin
                r_pc[i] <= RESET_PC;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (redirect_vld && (redirect_thr == 2'(i))) begin
                    r_pc[i] <= redirect_pc;
                end else if (w_accept && (w_pick_idx == 2'(i))) begin
                    r_pc[i] <= r_pc[i] + PC_INC;
                end
            end
        end
    end

    // F-stage registers and round-robin pointer. A new accept replaces any
    // fetch in F; otherwise a kill clears valid but leaves thr_f/pc_f alone;
    // otherwise an idle unstalled cycle empties F; a stall holds everything.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_thr_f    <= 4'b0000;
            r_pc_f     <= 48'd0;
            r_inst_vld <= 1'b0;
            r_last     <= 2'd3;
        end else if (w_accept) begin
            r_thr_f    <= w_thr_s;
            r_pc_f     <= r_pc[w_pick_idx];
            r_inst_vld <= 1'b1;
            r_last     <= w_pick_idx;
        end else if (w_kill) begin
            r_inst_vld <= 1'b0;
        end else if (!fetch_stall) begin
            r_thr_f    <= 4'b0000;
            r_inst_vld <= 1'b0;
        end
    end

    assign thr_s      = w_thr_s;
    assign running_s  = w_accept;
    assign thr_f      = r_thr_f;
    assign pc_f       = r_pc_f;
    assign inst_vld_f = r_inst_vld;
    assign t0pc_f     = r_pc[0];
    assign t1pc_f     = r_pc[1];
    assign t2pc_f     = r_pc[2];
    assign t3pc_f     = r_pc[3];

endmodule

// File: tb/tb_fetch_thr_sched.sv
// Bench for fetch_thr_sched: directed vector table, a mid-run reset sequence
// and randomized traffic, all checked against an abstract scheduler model.
module tb_fetch_thr_sched;

  localparam logic [47:0] RESET_PC = 48'h0000_0000_0020;
  localparam logic [47:0] PC_INC   = 48'd4;

  logic        clk;
  logic        rst_l;
  logic [3:0]  thr_rdy;
  logic [3:0]  thr_urgent;
  logic        fetch_stall;
  logic        redirect_vld;
  logic [1:0]  redirect_thr;
  logic [47:0] redirect_pc;
  logic [3:0]  thr_s;
  logic        running_s;
  logic [3:0]  thr_f;
  logic [47:0] pc_f;
  logic        inst_vld_f;
  logic [47:0] t0pc_f, t1pc_f, t2pc_f, t3pc_f;

  fetch_thr_sched #(.RESET_PC(RESET_PC), .PC_INC(PC_INC)) dut (
    .clk(clk), .rst_l(rst_l), .thr_rdy(thr_rdy), .thr_urgent(thr_urgent),
    .fetch_stall(fetch_stall), .redirect_vld(redirect_vld),
    .redirect_thr(redirect_thr), .redirect_pc(redirect_pc),
    .thr_s(thr_s), .running_s(running_s), .thr_f(thr_f), .pc_f(pc_f),
    .inst_vld_f(inst_vld_f), .t0pc_f(t0pc_f), .t1pc_f(t1pc_f),
    .t2pc_f(t2pc_f), .t3pc_f(t3pc_f)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  // reference model state: plain ints and an array of PCs
  longint unsigned m_pc [4];
  int              m_thr;     // -1 means no thread in F
  longint unsigned m_pcf;
  bit              m_vld;
  int              m_last;

  typedef struct {
    logic [3:0]  rdy;
    logic [3:0]  urg;
    logic        stall;
    logic        rvld;
    logic [1:0]  rthr;
    logic [47:0] rpc;
    logic [3:0]  e_s;
    logic [3:0]  e_f;
    logic [47:0] e_pc;
    logic        e_vld;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [3:0] rdy, input logic [3:0] urg,
                              input logic stall, input logic rvld,
                              input logic [1:0] rthr, input logic [47:0] rpc,
                              input logic [3:0] e_s, input logic [3:0] e_f,
                              input logic [47:0] e_pc, input logic e_vld);
    vec_t v;
    v.rdy = rdy; v.urg = urg; v.stall = stall; v.rvld = rvld;
    v.rthr = rthr; v.rpc = rpc; v.e_s = e_s; v.e_f = e_f;
    v.e_pc = e_pc; v.e_vld = e_vld;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_pc[i] = RESET_PC;
    m_thr  = -1;
    m_pcf  = 0;
    m_vld  = 0;
    m_last = 3;
  endfunction

  // which thread the scheduler should pick this cycle, -1 if none
  function automatic int model_pick(input logic [3:0] rdy, input logic [3:0] urg,
                                    input logic stall, input logic rvld,
                                    input logic [1:0] rthr);
    bit elig [4];
    bit any_urg;
    int t;
    if (stall) return -1;
    any_urg = 0;
    for (int i = 0; i < 4; i++) begin
      elig[i] = rdy[i] && !(rvld && (int'(rthr) == i));
      if (elig[i] && urg[i]) any_urg = 1;
    end
    for (int k = 1; k <= 4; k++) begin
      t = (m_last + k) % 4;
      if (elig[t] && (!any_urg || urg[t])) return t;
    end
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int t);
    logic [3:0] r;
    r = 4'b0000;
    if (t >= 0) r[t] = 1'b1;
    return r;
  endfunction

  function automatic void model_edge(input int p, input logic stall,
                                     input logic rvld, input logic [1:0] rthr,
                                     input logic [47:0] rpc);
    bit kill;
    kill = rvld && m_vld && (m_thr == int'(rthr));
    if (p >= 0) begin
      m_thr  = p;
      m_pcf  = m_pc[p];
      m_vld  = 1;
      m_last = p;
      m_pc[p] = (m_pc[p] + PC_INC) % (64'd1 << 48);
    end else if (kill) begin
      m_vld = 0;
    end else if (!stall) begin
      m_thr = -1;
      m_vld = 0;
    end
    if (rvld) m_pc[rthr] = rpc;
  endfunction

  task automatic check_regs(input string tag);
    cmp({tag, ".thr_f"}, 64'(thr_f), 64'(onehot(m_thr)));
    cmp({tag, ".pc_f"}, 64'(pc_f), m_pcf);
    cmp({tag, ".inst_vld_f"}, 64'(inst_vld_f), 64'(m_vld));
    cmp({tag, ".t0pc"}, 64'(t0pc_f), m_pc[0]);
    cmp({tag, ".t1pc"}, 64'(t1pc_f), m_pc[1]);
    cmp({tag, ".t2pc"}, 64'(t2pc_f), m_pc[2]);
    cmp({tag, ".t3pc"}, 64'(t3pc_f), m_pc[3]);
  endtask

  // driver: inputs at negedge, combinational check mid-low-phase,
  // registered check 1 time unit after the rising edge
  task automatic apply(input string tag, input logic [3:0] rdy, input logic [3:0] urg,
                       input logic stall, input logic rvld, input logic [1:0] rthr,
                       input logic [47:0] rpc, output logic [3:0] seen_s);
    int p;
    @(negedge clk);
    thr_rdy = rdy; thr_urgent = urg; fetch_stall = stall;
    redirect_vld = rvld; redirect_thr = rthr; redirect_pc = rpc;
    #1;
    p = model_pick(rdy, urg, stall, rvld, rthr);
    seen_s = thr_s;
    cmp({tag, ".thr_s"}, 64'(thr_s), 64'(onehot(p)));
    cmp({tag, ".running_s"}, 64'(running_s), 64'(p >= 0));
    @(posedge clk);
    model_edge(p, stall, rvld, rthr, rpc);
    #1;
    check_regs(tag);
  endtask

  initial begin
    logic [3:0] s;
    string tag;
    n_cmp = 0;
    n_fail = 0;
    thr_rdy = 4'h0; thr_urgent = 4'h0; fetch_stall = 1'b0;
    redirect_vld = 1'b0; redirect_thr = 2'd0; redirect_pc = 48'd0;
    rst_l = 1'b0;
    model_reset();
    #12;
    check_regs("reset");
    cmp("reset.thr_s", 64'(thr_s), 64'(4'h0));

    // directed vector table, starting right after reset release
    for (int k = 0; k < 8; k++)
      vt.push_back(mk(4'hF, 4'h0, 0, 0, 2'd0, 48'd0, 4'(1 << (k % 4)),
                      4'(1 << (k % 4)), 48'h20 + 48'(4 * (k / 4)), 1));
    vt.push_back(mk(4'hF, 4'h4, 0, 0, 2'd0, 48'd0, 4'h4, 4'h4, 48'h28, 1));
    vt.push_back(mk(4'hF, 4'h4, 0, 0, 2'd0, 48'd0, 4'h4, 4'h4, 48'h2C, 1));
    vt.push_back(mk(4'hF, 4'h4, 0, 0, 2'd0, 48'd0, 4'h4, 4'h4, 48'h30, 1));
    vt.push_back(mk(4'hF, 4'h0, 0, 0, 2'd0, 48'd0, 4'h8, 4'h8, 48'h28, 1));
    vt.push_back(mk(4'hF, 4'h0, 0, 0, 2'd0, 48'd0, 4'h1, 4'h1, 48'h28, 1));
    vt.push_back(mk(4'hF, 4'h0, 0, 0, 2'd0, 48'd0, 4'h2, 4'h2, 48'h28, 1));
    vt.push_back(mk(4'hF, 4'h0, 0, 0, 2'd0, 48'd0, 4'h4, 4'h4, 48'h34, 1));
    vt.push_back(mk(4'hF, 4'h0, 0, 0, 2'd0, 48'd0, 4'h8, 4'h8, 48'h2C, 1));
    vt.push_back(mk(4'hF, 4'h0, 0, 0, 2'd0, 48'd0, 4'h1, 4'h1, 48'h2C, 1));
    vt.push_back(mk(4'hF, 4'h0, 0, 0, 2'd0, 48'd0, 4'h2, 4'h2, 48'h2C, 1));
    for (int k = 0; k < 3; k++)
      vt.push_back(mk(4'hF, 4'h0, 1, 0, 2'd0, 48'd0, 4'h0, 4'h2, 48'h2C, 1));
    vt.push_back(mk(4'hF, 4'h0, 0, 0, 2'd0, 48'd0, 4'h4, 4'h4, 48'h38, 1));
    vt.push_back(mk(4'hF, 4'h0, 0, 0, 2'd0, 48'd0, 4'h8, 4'h8, 48'h30, 1));
    vt.push_back(mk(4'hF, 4'h0, 0, 0, 2'd0, 48'd0, 4'h1, 4'h1, 48'h30, 1));
    vt.push_back(mk(4'hF, 4'h0, 0, 0, 2'd0, 48'd0, 4'h2, 4'h2, 48'h30, 1));
    vt.push_back(mk(4'h2, 4'h0, 0, 1, 2'd1, 48'h8000, 4'h0, 4'h2, 48'h30, 0));
    vt.push_back(mk(4'hF, 4'h0, 0, 0, 2'd0, 48'd0, 4'h4, 4'h4, 48'h3C, 1));
    vt.push_back(mk(4'hF, 4'h0, 0, 0, 2'd0, 48'd0, 4'h8, 4'h8, 48'h34, 1));
    vt.push_back(mk(4'hF, 4'h0, 0, 0, 2'd0, 48'd0, 4'h1, 4'h1, 48'h34, 1));
    vt.push_back(mk(4'hF, 4'h0, 0, 0, 2'd0, 48'd0, 4'h2, 4'h2, 48'h8000, 1));
    vt.push_back(mk(4'h0, 4'h0, 0, 1, 2'd3, 48'hFFFF_FFFF_FFFC, 4'h0, 4'h0, 48'h8000, 0));
    vt.push_back(mk(4'h0, 4'h0, 0, 0, 2'd0, 48'd0, 4'h0, 4'h0, 48'h8000, 0));
    vt.push_back(mk(4'h8, 4'h0, 0, 0, 2'd0, 48'd0, 4'h8, 4'h8, 48'hFFFF_FFFF_FFFC, 1));
    vt.push_back(mk(4'hF, 4'h0, 0, 0, 2'd0, 48'd0, 4'h1, 4'h1, 48'h38, 1));

    @(negedge clk);
    rst_l = 1'b1;
    for (int i = 0; i < vt.size(); i++) begin
      tag = $sformatf("vec%0d", i);
      apply(tag, vt[i].rdy, vt[i].urg, vt[i].stall, vt[i].rvld,
            vt[i].rthr, vt[i].rpc, s);
      cmp({tag, ".tbl_thr_s"}, 64'(s), 64'(vt[i].e_s));
      cmp({tag, ".tbl_thr_f"}, 64'(thr_f), 64'(vt[i].e_f));
      cmp({tag, ".tbl_pc_f"}, 64'(pc_f), 64'(vt[i].e_pc));
      cmp({tag, ".tbl_vld"}, 64'(inst_vld_f), 64'(vt[i].e_vld));
      if (i == 7) begin
        cmp("rot.t0pc", 64'(t0pc_f), 64'h28);
        cmp("rot.t1pc", 64'(t1pc_f), 64'h28);
        cmp("rot.t2pc", 64'(t2pc_f), 64'h28);
        cmp("rot.t3pc", 64'(t3pc_f), 64'h28);
      end
      if (i == 25) cmp("redir.t1pc", 64'(t1pc_f), 64'h8000);
      if (i == 29) cmp("refetch.t1pc", 64'(t1pc_f), 64'h8004);
      if (i == 32) cmp("wrap.t3pc", 64'(t3pc_f), 64'h0);
    end

    // hand sequence: pick a thread, stall, then reset while the stalled
    // fetch is held; reset must clear state without waiting for an edge
    apply("pre_rst", 4'hF, 4'h0, 0, 0, 2'd0, 48'd0, s);
    apply("pre_rst_stall", 4'hF, 4'h0, 1, 0, 2'd0, 48'd0, s);
    #2;
    rst_l = 1'b0;
    model_reset();
    #1;
    check_regs("async_rst");
    @(negedge clk);
    rst_l = 1'b1;
    apply("post_rst", 4'hF, 4'h0, 0, 0, 2'd0, 48'd0, s);
    cmp("post_rst.first_thr", 64'(thr_f), 64'h1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [47:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? 48'hFFFF_FFFF_FFF0 + 48'(4 * $urandom_range(0, 3))
                                        : {16'($urandom), 32'($urandom)};
      apply($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
            2'($urandom_range(0, 3)), rpc, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_thr_sched.md
# fetch_thr_sched

Four-thread fetch scheduler for the IFU F-stage. Each cycle it picks one runnable thread, round-robin with an urgent-priority override, and drives the one-hot F-stage thread select, the selected PC and an instruction-valid flag. It owns the four per-thread fetch PC registers: sequential increment on fetch, overwrite on redirect. Its outputs `thr_f`, `pc_f`, `t0pc_f`..`t3pc_f` and `inst_vld_f` are the signals the PC-select checker compares per core.

## Interface
- `RESET_PC`, default 48'h0000_0000_0020: value loaded into every thread PC on reset.
- `PC_INC`, default 48'd4: increment applied to a thread PC on each accepted fetch.
- `clk` input 1: core clock; all state on rising edge.
- `rst_l` input 1: reset, asynchronous assert, active-low.
- `thr_rdy` input 4: per-thread runnable; bit i = thread i.
- `thr_urgent` input 4: per-thread urgent request; ignored unless the matching `thr_rdy` bit is set.
- `fetch_stall` input 1: F-stage cannot accept a new fetch this cycle.
- `redirect_vld` input 1: load a new PC for one thread.
- `redirect_thr` input 2: thread index for redirect.
- `redirect_pc` input 48: redirect target PC.
- `thr_s` output 4: combinational one-hot S-stage pick; 0 if none.
- `running_s` output 1: `|thr_s`.
- `thr_f` output 4: registered one-hot F-stage thread.
- `pc_f` output 48: registered PC of `thr_f`.
- `inst_vld_f` output 1: registered; F-stage holds a valid fetch.
- `t0pc_f`, `t1pc_f`, `t2pc_f`, `t3pc_f` output 48 each: current per-thread PC registers.

## Operation
- Eligible set: `elig = thr_rdy & ~redir_mask`, where `redir_mask` is the one-hot of `redirect_thr` when `redirect_vld`=1, else 0. A thread being redirected is never picked in the same cycle.
- Urgent set: `urg = elig & thr_urgent`. The search set is `urg` if it is non-zero, else `elig`.
- Pick rule: round-robin from `last+1` mod 4 through the search set; the first set bit wins.
- `thr_s` = pick when `fetch_stall`=0, else 0. It is purely combinational from state and inputs.
- Accept occurs when `thr_s` != 0. On the accept edge:
  - `thr_f` <= `thr_s`, `pc_f` <= old PC of the picked thread, `inst_vld_f` <= 1.
  - The picked PC <= PC + `PC_INC`, mod 2^48 (wraps to 0, no saturation).
  - `last` <= picked index.
- No stall and no pick: `thr_f` <= 0, `inst_vld_f` <= 0, `pc_f` holds, `last` holds.
- Stall (`fetch_stall`=1): `thr_f`, `pc_f`, `inst_vld_f` hold; no PC increments; `last` holds.
- Redirect:
  - Thread `redirect_thr` PC <= `redirect_pc` at the edge, including during a stall.
  - An increment can never coincide with a redirect for the same thread, because of `redir_mask`.
  - If `inst_vld_f`=1 and `thr_f` = the redirected thread, `inst_vld_f` <= 0 (kill) at the same edge, stalled or not. `thr_f` and `pc_f` keep their values.
- Urgent never starves non-urgent indefinitely only if software bounds urgent. No aging counter is implemented.

## Timing
- Reset (async, `rst_l`=0):
  - `t0pc_f`..`t3pc_f` = `RESET_PC`.
  - `thr_f`=0, `pc_f`=0, `inst_vld_f`=0.
  - `last`=3, so thread 0 wins first.
- Reset release takes effect on the first rising edge with `rst_l`=1.
- Reset mid-operation clears all state immediately, including a held stalled fetch.
- Latency:
  - Select to F-stage: 1 cycle (pick in cycle N, `thr_f`/`pc_f` valid in N+1).
  - Redirect to first fetch at the new PC: redirect in N, earliest pick in N+1, `pc_f`=`redirect_pc` in N+2.
- Invariant at every rising edge with `inst_vld_f`=1: `pc_f` = `tXpc_f` − `PC_INC` for X = `thr_f`, unless X was redirected since it was picked, in which case `inst_vld_f` is 0.
- `thr_s` and `thr_f` are always one-hot or zero.

## Test plan
- Reset, all `thr_rdy`=4'hF, no stall for 8 cycles -> `thr_f` sequence 1,2,4,8,1,2,4,8. `pc_f` = 0x20,0x20,0x20,0x20,0x24,0x24,…. Each `tXpc_f` ends at 0x28.
- `thr_rdy`=4'hF with `thr_urgent`=4'b0100 for 3 cycles, then 0 -> `thr_f` 4,4,4, then rotation resumes 8,1,2.
- `fetch_stall`=1 for 3 cycles after T1 is picked -> `thr_f`=2, `pc_f`, `inst_vld_f`=1 and all PCs held. T2 picked on the first unstalled cycle.
- `redirect_vld`=1, `redirect_thr`=1, `redirect_pc`=48'h8000 while T1 is in F -> `inst_vld_f`=0 next cycle, `t1pc_f`=0x8000. T1 is not picked in the redirect cycle. A later T1 fetch shows `pc_f`=0x8000, then `t1pc_f`=0x8004.
- Redirect T3 to 48'hFFFF_FFFF_FFFC, then fetch T3 -> `pc_f`=0xFFFF_FFFF_FFFC, `t3pc_f` wraps to 0.
- `thr_rdy`=0 for 2 cycles -> `thr_s`=0, `running_s`=0, `inst_vld_f`=0, `thr_f`=0, `last` unchanged. The next pick follows the prior order.
